// File: rtl/interp_window_ctrl_if.sv
// Handshake bundle between the interpolation window controller and its
// pixel source, previous-row queue and downstream consumer.
interface interp_window_ctrl_if;
    logic pix_val;
    logic pix_rdy;
    logic enq_val;
    logic enq_rdy;
    logic deq_rdy;
    logic deq_val;
    logic out_val;
    logic out_rdy;

    modport master (
        input  pix_val, enq_rdy, deq_val, out_rdy,
        output pix_rdy, enq_val, deq_rdy, out_val
    );

    modport slave (
        output pix_val, enq_rdy, deq_val, out_rdy,
        input  pix_rdy, enq_val, deq_rdy, out_val
    );
endinterface

// File: rtl/interp_window_ctrl.sv
// Control unit for the bilinear interpolation datapath: walks raster windows,
// drives the previous-row queue and tracks result valids through the datapath.
module interp_window_ctrl #(
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned WIN_CNT_W = 8,
    parameter int unsigned PIPE_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     win_dim,
    input  logic [WIN_CNT_W-1:0] num_win,
    interp_window_ctrl_if.master hs,
    output logic [CNT_W-1:0]     col_idx,
    output logic [CNT_W-1:0]     row_idx,
    output logic                 pipe_en,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] CALC  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]           state;
    logic [CNT_W-1:0]     dim_q;
    logic [WIN_CNT_W-1:0] nwin_q;
    logic [WIN_CNT_W-1:0] win_cnt;
    logic [PIPE_LAT-1:0]  vld;

    logic stall;
    logic acc;
    logic need_enq;
    logic need_deq;
    logic col_end;
    logic row_end;
    logic last_win;
    logic v_in;
    logic pipe_empty;

    assign hs.out_val = vld[PIPE_LAT-1];
    assign stall      = hs.out_val && !hs.out_rdy;
    assign pipe_en    = !stall;

    assign need_enq = row_idx < dim_q;
    assign need_deq = row_idx != '0;

    assign hs.pix_rdy = ((state == FILL) || (state == CALC)) && !stall &&
                        (!need_enq || hs.enq_rdy) && (!need_deq || hs.deq_val);
    assign acc        = hs.pix_val && hs.pix_rdy;
    assign hs.enq_val = acc && need_enq;
    assign hs.deq_rdy = acc && need_deq;

    assign col_end  = col_idx == dim_q;
    assign row_end  = row_idx == dim_q;
    assign last_win = win_cnt == (nwin_q - WIN_CNT_W'(1));

    // A result exists only once a 2x2 neighbourhood is complete
    assign v_in = acc && need_deq && (col_idx != '0);

    // Every stage except the output one must be empty before the job can retire
    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned i = 0; i + 1 < PIPE_LAT; i++) begin
            if (vld[i]) begin
                pipe_empty = 1'b0;
            end
        end
    end

    assign busy = state != IDLE;
    assign done = (state == DRAIN) && pipe_empty && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
        end else if (!stall) begin
            vld[0] <= v_in;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            dim_q   <= '0;
            nwin_q  <= '0;
            win_cnt <= '0;
            col_idx <= '0;
            row_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dim_q   <= (win_dim == '0) ? CNT_W'(1) : win_dim;
                        nwin_q  <= (num_win == '0) ? WIN_CNT_W'(1) : num_win;
                        win_cnt <= '0;
                        col_idx <= '0;
                        row_idx <= '0;
                        state   <= FILL;
                    end
                end
                FILL, CALC: begin
                    if (acc) begin
                        if (col_end) begin
                            col_idx <= '0;
                            if (row_end) begin
                                row_idx <= '0;
                                win_cnt <= win_cnt + WIN_CNT_W'(1);
                            end else begin
                                row_idx <= row_idx + CNT_W'(1);
                            end
                        end else begin
                            col_idx <= col_idx + CNT_W'(1);
                        end
                        if (col_end && state == FILL) begin
                            state <= CALC;
                        end else if (col_end && row_end) begin
                            state <= last_win ? DRAIN : FILL;
                        end
                    end
                end
                DRAIN: begin
                    if (pipe_empty && !stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interp_window_ctrl.sv
// Bench for interp_window_ctrl: table-driven jobs, hand-built corner sequences
// and randomized handshakes, all checked cycle by cycle against a token model.
module tb_interp_window_ctrl;

    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] win_dim;
    logic [7:0] num_win;
    logic [4:0] col_idx;
    logic [4:0] row_idx;
    logic       pipe_en;
    logic       busy;
    logic       done;

    interp_window_ctrl_if hs();

    interp_window_ctrl #(
        .CNT_W    (5),
        .WIN_CNT_W(8),
        .PIPE_LAT (LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .win_dim(win_dim),
        .num_win(num_win),
        .hs     (hs),
        .col_idx(col_idx),
        .row_idx(row_idx),
        .pipe_en(pipe_en),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: accept count within the job plus a queue of result tokens with their age
    bit m_active = 1'b0;
    int m_d = 1;
    int m_n = 1;
    int m_k = 0;
    int m_total = 0;
    int ages[$];

    int cyc = 0;
    int c_acc, c_enq, c_deq, c_out, c_done;
    int first_out_cyc, acc5_cyc;
    int hk_mode = 0;
    int hk_cnt = 0;

    typedef struct {
        int d;
        int n;
        bit rnd;
        int acc;
        int enq;
        int deq;
        int outs;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cycle_check();
        int pos, er, ec;
        bit eo, es, erdy, eacc, edone;
        @(negedge clk);
        cyc++;
        pos  = m_k % ((m_d + 1) * (m_d + 1));
        er   = pos / (m_d + 1);
        ec   = pos % (m_d + 1);
        eo   = (ages.size() > 0) && (ages[0] == LAT);
        es   = eo && !hs.out_rdy;
        erdy = m_active && (m_k < m_total) && !es &&
               (er == m_d || hs.enq_rdy) && (er == 0 || hs.deq_val);
        eacc = erdy && hs.pix_val;
        edone = m_active && (m_k == m_total) &&
                (ages.size() == 0 || (ages.size() == 1 && eo && hs.out_rdy));

        chk("pix_rdy", hs.pix_rdy, erdy);
        chk("enq_val", hs.enq_val, eacc && (er < m_d));
        chk("deq_rdy", hs.deq_rdy, eacc && (er > 0));
        chk("out_val", hs.out_val, eo);
        chk("pipe_en", pipe_en, !es);
        chk("busy", busy, m_active);
        chk("done", done, edone);
        chk("row_idx", row_idx, er);
        chk("col_idx", col_idx, ec);

        if (hk_mode == 1 && !hs.out_rdy) begin
            chk("stall_out_held", hs.out_val, 1);
            chk("stall_pix_rdy", hs.pix_rdy, 0);
            chk("stall_pipe_en", pipe_en, 0);
        end
        if (hk_mode == 2 && !hs.deq_val) begin
            chk("deqhold_pix_rdy", hs.pix_rdy, 0);
            chk("deqhold_enq_val", hs.enq_val, 0);
            chk("deqhold_deq_rdy", hs.deq_rdy, 0);
        end

        if (!reset) begin
            if (hs.pix_val && hs.pix_rdy) begin
                c_acc++;
                if (c_acc == 5) acc5_cyc = cyc;
            end
            if (hs.enq_val) c_enq++;
            if (hs.deq_rdy) c_deq++;
            if (hs.out_val && first_out_cyc < 0) first_out_cyc = cyc;
            if (hs.out_val && hs.out_rdy) c_out++;
            if (done) c_done++;
        end

        if (reset) begin
            m_active = 1'b0;
            m_k = 0;
            ages.delete();
        end else begin
            if (eo && hs.out_rdy) void'(ages.pop_front());
            if (!es) foreach (ages[i]) ages[i]++;
            if (eacc) begin
                m_k++;
                if (er > 0 && ec > 0) ages.push_back(1);
            end
            if (edone) begin
                m_active = 1'b0;
                m_k = 0;
            end else if (!m_active && start) begin
                m_d = (win_dim == 0) ? 1 : int'(win_dim);
                m_n = (num_win == 0) ? 1 : int'(num_win);
                m_total = m_n * (m_d + 1) * (m_d + 1);
                m_k = 0;
                m_active = 1'b1;
            end
        end
    endtask

    task automatic step();
        cycle_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input bit rnd);
        hs.pix_val = rnd ? ($urandom_range(3) != 0) : 1'b1;
        hs.enq_rdy = rnd ? ($urandom_range(4) != 0) : 1'b1;
        hs.deq_val = rnd ? ($urandom_range(4) != 0) : 1'b1;
        hs.out_rdy = rnd ? ($urandom_range(2) != 0) : 1'b1;
        if (hk_mode == 1 && first_out_cyc >= 0 && hk_cnt < 5) begin
            hs.out_rdy = 1'b0;
            hk_cnt++;
        end
        if (hk_mode == 2 && m_k == m_d + 3 && hk_cnt < 3) begin
            hs.deq_val = 1'b0;
            hk_cnt++;
        end
    endtask

    task automatic clear_counts();
        c_acc = 0; c_enq = 0; c_deq = 0; c_out = 0; c_done = 0;
        first_out_cyc = -1;
        acc5_cyc = -1;
        hk_cnt = 0;
    endtask

    task automatic run_job(input int d, input int n, input bit rnd);
        clear_counts();
        win_dim = 5'(d);
        num_win = 8'(n);
        start = 1'b1;
        set_inputs(rnd);
        step();
        start = 1'b0;
        for (int i = 0; i < 4000 && c_done == 0; i++) begin
            set_inputs(rnd);
            step();
        end
        chk("done_count", c_done, 1);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_counts(input string tag, input int a, input int e, input int q, input int o);
        chk({tag, "_acc"}, c_acc, a);
        chk({tag, "_enq"}, c_enq, e);
        chk({tag, "_deq"}, c_deq, q);
        chk({tag, "_out"}, c_out, o);
    endtask

    initial begin
        vec_t tbl[7];
        int dd, nn;
        tbl = '{
            '{2, 1, 1'b0,  9,  6,  6,  4},
            '{3, 2, 1'b0, 32, 24, 24, 18},
            '{0, 1, 1'b0,  4,  2,  2,  1},
            '{1, 3, 1'b1, 12,  6,  6,  3},
            '{4, 1, 1'b1, 25, 20, 20, 16},
            '{3, 2, 1'b1, 32, 24, 24, 18},
            '{2, 0, 1'b1,  9,  6,  6,  4}
        };

        reset = 1'b1;
        start = 1'b0;
        win_dim = '0;
        num_win = '0;
        hs.pix_val = 1'b1;
        hs.enq_rdy = 1'b1;
        hs.deq_val = 1'b1;
        hs.out_rdy = 1'b1;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pix_rdy", hs.pix_rdy, 0);
        chk("rst_enq_val", hs.enq_val, 0);
        chk("rst_deq_rdy", hs.deq_rdy, 0);
        chk("rst_out_val", hs.out_val, 0);
        chk("rst_row", row_idx, 0);
        chk("rst_col", col_idx, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_job(tbl[i].d, tbl[i].n, tbl[i].rnd);
            chk_counts($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].enq, tbl[i].deq, tbl[i].outs);
            if (i == 0) chk("first_out_latency", first_out_cyc - acc5_cyc, LAT);
        end

        hk_mode = 1;
        run_job(2, 1, 1'b0);
        chk_counts("stall", 9, 6, 6, 4);
        hk_mode = 2;
        run_job(3, 1, 1'b0);
        chk_counts("deqhold", 16, 12, 12, 9);
        hk_mode = 0;

        // Reset mid-window at row 1 col 1, then a fresh minimal job
        clear_counts();
        win_dim = 5'd2;
        num_win = 8'd1;
        start = 1'b1;
        set_inputs(1'b0);
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && m_k != m_d + 2; i++) begin
            set_inputs(1'b0);
            step();
        end
        chk("pre_reset_row", row_idx, 1);
        chk("pre_reset_col", col_idx, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pix_rdy", hs.pix_rdy, 0);
        chk("mid_rst_enq_val", hs.enq_val, 0);
        chk("mid_rst_deq_rdy", hs.deq_rdy, 0);
        chk("mid_rst_out_val", hs.out_val, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_row", row_idx, 0);
        chk("mid_rst_col", col_idx, 0);
        run_job(1, 1, 1'b0);
        chk_counts("after_rst", 4, 2, 2, 1);

        for (int r = 0; r < 8; r++) begin
            int d, n;
            d = $urandom_range(5);
            n = $urandom_range(3);
            dd = (d == 0) ? 1 : d;
            nn = (n == 0) ? 1 : n;
            run_job(d, n, 1'b1);
            chk_counts($sformatf("rnd%0d", r), nn * (dd + 1) * (dd + 1),
                       nn * dd * (dd + 1), nn * dd * (dd + 1), nn * dd * dd);
            repeat (3) begin
                set_inputs(1'b1);
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
